// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: operation encodings, FSM states and
// the legality check on the 4-bit select code.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    SUB   = 4'b0001,
    MUL   = 4'b0010,
    DIV   = 4'b0011,
    AND   = 4'b0100,
    OR    = 4'b0101,
    XOR   = 4'b0110,
    SHL   = 4'b0111,
    SHR   = 4'b1000,
    PASSB = 4'b1011,
    CMP   = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  function automatic logic is_legal_op(input logic [3:0] sel);
    logic legal;
    case (sel)
      4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b1111: legal = 1'b0;
      default:                                     legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shift-add multiply / restoring divide iteration state. Each step borrows
// one add (MUL) or sub (DIV) from the external ALU via alu_in0/alu_in1/alu_out.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [3:0]       alu_sel,
  output logic             last,
  output logic [WIDTH-1:0] res_nx,
  output logic [WIDTH-1:0] rem_nx
);

  localparam int CW = $clog2(ITERS);

  // acc: P (MUL) or R (DIV); sh: M or N; opd: Q or D
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opd_q, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   rp_s;
  logic             ge_s;

  // Iteration datapath and ALU drive for the current RUN cycle
  always_comb begin
    rp_s  = {acc_q, sh_q[WIDTH-1]};
    ge_s  = rp_s[WIDTH] | (rp_s[WIDTH-1:0] >= opd_q);
    acc_d = acc_q;
    sh_d  = sh_q;
    opd_d = opd_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      acc_d = {WIDTH{1'b0}};
      sh_d  = op_a;
      opd_d = op_b;
      cnt_d = CW'(ITERS - 1);
      div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        acc_d = ge_s ? alu_out : rp_s[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], ge_s};
      end else begin
        acc_d = opd_q[0] ? alu_out : acc_q;
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        opd_d = {1'b0, opd_q[WIDTH-1:1]};
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (div_q) begin
      alu_sel = SUB;
      alu_in0 = rp_s[WIDTH-1:0];
      alu_in1 = opd_q;
      res_nx  = sh_d;
      rem_nx  = acc_d;
    end else begin
      alu_sel = ADD;
      alu_in0 = acc_q;
      alu_in1 = sh_q;
      res_nx  = acc_d;
      rem_nx  = {WIDTH{1'b0}};
    end
    last = (cnt_q == {CW{1'b0}});
  end

  // Iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {WIDTH{1'b0}};
      sh_q  <= {WIDTH{1'b0}};
      opd_q <= {WIDTH{1'b0}};
      cnt_q <= {CW{1'b0}};
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Valid/ready front end for the 16-bit ALU: single-cycle ops pass through,
// MUL/DIV run as ITERS-cycle sequences through muldiv_iter.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             flag_dz,
  output logic             flag_illegal,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out
);

  seq_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
  logic             flag_dz_q, flag_dz_d, flag_illegal_q, flag_illegal_d;
  logic             accept_s, load_s, step_s, last_s;
  logic [WIDTH-1:0] md_in0_s, md_in1_s, res_nx_s, rem_nx_s;
  logic [3:0]       md_sel_s;

  assign accept_s = in_valid && in_ready_q;
  assign step_s   = (state_q == RUN);

  muldiv_iter #(.WIDTH(WIDTH), .ITERS(ITERS)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .step    (step_s),
    .is_div  (op_sel == DIV),
    .op_a    (op_a),
    .op_b    (op_b),
    .alu_out (alu_out),
    .alu_in0 (md_in0_s),
    .alu_in1 (md_in1_s),
    .alu_sel (md_sel_s),
    .last    (last_s),
    .res_nx  (res_nx_s),
    .rem_nx  (rem_nx_s)
  );

  // Next-state, result capture and ALU port mux
  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    remainder_d    = remainder_q;
    flag_dz_d      = flag_dz_q;
    flag_illegal_d = flag_illegal_q;
    load_s         = 1'b0;
    alu_sel        = 4'b0000;
    alu_in0        = {WIDTH{1'b0}};
    alu_in1        = {WIDTH{1'b0}};
    case (state_q)
      IDLE: begin
        alu_sel = op_sel;
        alu_in0 = op_a;
        alu_in1 = op_b;
        if (accept_s) begin
          flag_dz_d      = 1'b0;
          flag_illegal_d = 1'b0;
          remainder_d    = {WIDTH{1'b0}};
          if (!is_legal_op(op_sel)) begin
            state_d        = DONE;
            result_d       = {WIDTH{1'b0}};
            flag_illegal_d = 1'b1;
          end else if (op_sel == DIV && op_b == {WIDTH{1'b0}}) begin
            state_d     = DONE;
            result_d    = {WIDTH{1'b1}};
            remainder_d = op_a;
            flag_dz_d   = 1'b1;
          end else if (op_sel == MUL || op_sel == DIV) begin
            // result/remainder keep the previous op's values until DONE
            state_d     = RUN;
            load_s      = 1'b1;
            remainder_d = remainder_q;
          end else begin
            state_d  = DONE;
            result_d = alu_out;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        alu_sel = md_sel_s;
        alu_in0 = md_in0_s;
        alu_in1 = md_in1_s;
        if (last_s) begin
          state_d     = DONE;
          result_d    = res_nx_s;
          remainder_d = rem_nx_s;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      result_q       <= {WIDTH{1'b0}};
      remainder_q    <= {WIDTH{1'b0}};
      flag_dz_q      <= 1'b0;
      flag_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      remainder_q    <= remainder_d;
      flag_dz_q      <= flag_dz_d;
      flag_illegal_q <= flag_illegal_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign remainder    = remainder_q;
  assign flag_dz      = flag_dz_q;
  assign flag_illegal = flag_illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the external ALU.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, flag_dz, flag_illegal;
  logic [3:0]  op_sel, alu_sel;
  logic [15:0] op_a, op_b, result, remainder, alu_in0, alu_in1, alu_out;
  int          checks = 0;
  int          failures = 0;
  int          lat;
  logic        bad_ready, bad_sel, issue_to;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .result(result), .remainder(remainder), .flag_dz(flag_dz),
    .flag_illegal(flag_illegal), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_sel(alu_sel), .alu_out(alu_out)
  );

  // external ALU: no native multiply or divide
  always_comb begin
    case (alu_sel)
      4'b0000: alu_out = alu_in0 + alu_in1;
      4'b0001: alu_out = alu_in0 - alu_in1;
      4'b0100: alu_out = alu_in0 & alu_in1;
      4'b0101: alu_out = alu_in0 | alu_in1;
      4'b0110: alu_out = alu_in0 ^ alu_in1;
      4'b0111: alu_out = alu_in0 << alu_in1;
      4'b1000: alu_out = alu_in0 >> alu_in1;
      4'b1011: alu_out = alu_in1;
      4'b1100: alu_out = alu_in0 - alu_in1;
      default: alu_out = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns at the negedge one cycle after the accepting edge
  task automatic issue(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                       input logic hold);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op_sel = sel; op_a = a; op_b = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    issue_to = (n >= 50);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    lat = 1; bad_ready = 1'b0; bad_sel = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad_ready = 1'b1;
      if (alu_sel !== 4'b0000) bad_sel = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic do_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
    issue(sel, a, b, 1'b0);
    check("issue_timeout", {31'd0, issue_to}, 32'd0);
    wait_done();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_sel = 4'b0000; op_a = 16'h0; op_b = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {30'd0, flag_dz, flag_illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);

    do_op(4'b0000, 16'd13, 16'd6);
    check("add_lat", lat, 32'd1);
    check("add_res", {16'd0, result}, 32'd19);
    check("add_rem", {16'd0, remainder}, 32'd0);
    @(negedge clk);
    check("add_pulse_one_cycle", {31'd0, out_valid}, 32'd0);

    do_op(4'b0001, 16'd13, 16'd6);
    check("sub_res", {16'd0, result}, 32'd7);
    do_op(4'b0111, 16'd13, 16'd6);
    check("shl_res", {16'd0, result}, 32'd832);
    do_op(4'b0110, 16'h00F0, 16'h0FF0);
    check("xor_res", {16'd0, result}, 32'h0F00);

    do_op(4'b0010, 16'd13, 16'd6);
    check("mul_lat", lat, 32'd17);
    check("mul_res", {16'd0, result}, 32'd78);
    check("mul_rem", {16'd0, remainder}, 32'd0);
    check("mul_ready_low", {31'd0, bad_ready}, 32'd0);
    check("mul_alu_sel_add", {31'd0, bad_sel}, 32'd0);

    do_op(4'b0010, 16'hFFFF, 16'hFFFF);
    check("mul_wrap", {16'd0, result}, 32'h0001);

    do_op(4'b0011, 16'd13, 16'd6);
    check("div_lat", lat, 32'd17);
    check("div_quot", {16'd0, result}, 32'd2);
    check("div_rem", {16'd0, remainder}, 32'd1);

    do_op(4'b0011, 16'hFFFF, 16'h8001);
    check("div_big_quot", {16'd0, result}, 32'd1);
    check("div_big_rem", {16'd0, remainder}, 32'h7FFE);

    do_op(4'b0011, 16'd5, 16'd0);
    check("dz_lat", lat, 32'd1);
    check("dz_res", {16'd0, result}, 32'hFFFF);
    check("dz_rem", {16'd0, remainder}, 32'd5);
    check("dz_flag", {31'd0, flag_dz}, 32'd1);

    do_op(4'b1111, 16'd13, 16'd6);
    check("ill_res", {16'd0, result}, 32'd0);
    check("ill_flag", {30'd0, flag_dz, flag_illegal}, 32'd1);

    // second request held through a MUL
    issue(4'b0010, 16'd13, 16'd6, 1'b1);
    op_sel = 4'b0000;
    wait_done();
    check("held_mul_lat", lat, 32'd17);
    check("held_mul_res", {16'd0, result}, 32'd78);
    check("held_flags_clear", {30'd0, flag_dz, flag_illegal}, 32'd0);
    @(negedge clk);
    check("held_not_yet", {31'd0, out_valid}, 32'd0);
    check("held_idle_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_add_valid", {31'd0, out_valid}, 32'd1);
    check("held_add_res", {16'd0, result}, 32'd19);

    // reset during RUN of a DIV, after a div-by-zero left non-zero outputs
    do_op(4'b0011, 16'd9, 16'd0);
    issue(4'b0011, 16'd100, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_outs", {result, remainder}, 32'd0);
    check("midrst_flags", {30'd0, flag_dz, flag_illegal}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    lat = 0;
    repeat (20) begin
      if (out_valid) lat++;
      @(negedge clk);
    end
    check("midrst_no_valid", lat, 32'd0);
    do_op(4'b0000, 16'd13, 16'd6);
    check("post_rst_add", {16'd0, result}, 32'd19);
    check("post_rst_lat", lat, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer that owns the 16-bit `alu` datapath and presents a valid/ready operation interface to the decode stage.
- Single-cycle ALU ops pass straight through to the ALU.
- Select codes 0010 (MUL) and 0011 (DIV) are implemented as 16-iteration multi-cycle sequences. Each iteration uses one ALU add or sub per cycle, so the ALU needs no native multiplier or divider.
- Sits between the instruction decoder and the `alu` instance; it is the only driver of the ALU's `in0`/`in1`/`select`.

Parameters:
- WIDTH, 16, datapath width (operands, ALU ports, result).
- ITERS, WIDTH, MUL/DIV iteration count. Must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request; high only in IDLE.
- op_sel  in  4  ALU select encoding (0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 xor, 0111 shl, 1000 shr, 1011 pass-b, 1100 cmp/sub).
- op_a  in  WIDTH  operand A (multiplicand or dividend).
- op_b  in  WIDTH  operand B (multiplier or divisor).
- out_valid  out  1  one-cycle pulse; result, remainder and flags are valid.
- result  out  WIDTH  op result; low WIDTH bits of the product; quotient for DIV.
- remainder  out  WIDTH  DIV remainder; 0 for all other ops.
- flag_dz  out  1  DIV with op_b==0.
- flag_illegal  out  1  op_sel in {1001,1010,1101,1110,1111}.
- alu_in0  out  WIDTH  to alu.in0.
- alu_in1  out  WIDTH  to alu.in1.
- alu_sel  out  4  to alu.select.
- alu_out  in  WIDTH  from alu.out (combinational).

Behaviour:
- Reset
  - State is IDLE.
  - out_valid, result, remainder, flag_dz, flag_illegal are all 0.
  - in_ready is 0 while rst=1 and goes to 1 in the first cycle after rst deasserts.
- FSM states: IDLE, RUN, DONE.
- Accept: occurs on a clock edge where in_valid && in_ready. While in_ready=0, in_valid is ignored; the requester holds its request.
- ALU drive
  - IDLE: alu_sel=op_sel, alu_in0=op_a, alu_in1=op_b (combinational pass-through).
  - RUN: driven as described under MUL and DIV below.
  - DONE: all ALU drive signals are 0.
- Simple op (legal op_sel, not 0010/0011)
  - At accept: latch alu_out into result; go to DONE.
  - out_valid is high in the cycle after accept (latency 1).
  - Throughput: one op per 2 cycles.
- Illegal op_sel: IDLE→DONE with result=0, flag_illegal=1.
- MUL (IDLE→RUN)
  - At accept, latch P=0, M=op_a, Q=op_b, cnt=ITERS-1.
  - Each RUN cycle: alu_sel=0000, alu_in0=P, alu_in1=M.
  - If Q[0]: P←alu_out. Then M←M<<1, Q←Q>>1 (local shifts).
  - Wraps modulo 2^WIDTH; the upper product bits are discarded.
- DIV, op_b≠0 (IDLE→RUN)
  - At accept, latch R=0, N=op_a, D=op_b, cnt=ITERS-1.
  - Each RUN cycle:
    - Form the (WIDTH+1)-bit value R'={R,N[MSB]} and shift N left by 1.
    - Drive alu_sel=0001, alu_in0=R'[WIDTH-1:0], alu_in1=D.
    - If R'[WIDTH]==1 or R'[WIDTH-1:0]>=D (local compare): R←alu_out and shift quotient bit 1 into N[0].
    - Otherwise: R←R'[WIDTH-1:0] and shift in 0.
  - At DONE: result=N (quotient), remainder=R.
- DIV, op_b==0: no RUN. IDLE→DONE with result=all-ones, remainder=op_a, flag_dz=1.
- RUN exit: after the cnt==0 iteration, go to DONE. out_valid rises ITERS+1 = 17 cycles after accept.
- DONE: out_valid=1 for exactly one cycle, in_ready=0; next state is IDLE.
- Output hold: result, remainder and flags hold their values until the next out_valid. Flags clear at the next accept.
- Reset mid-RUN or mid-DONE: next cycle is IDLE with all outputs 0; no out_valid is produced for the aborted op.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with ADD, SUB, MUL, DIV, AND, OR, XOR, SHL, SHR, PASSB=4'b1011, CMP=4'b1100;
  - typedef enum of FSM states;
  - constant WIDTH_DEFAULT=16;
  - function is_legal_op().
- One sub-module is natural: muldiv_iter. It holds the P/M/Q or R/N/D registers and the iteration counter, and takes alu_out back in.
- The top level keeps the FSM, the handshake, and the ALU port mux.

Test Plan:
- ADD op_a=13, op_b=6, op_sel=0000 → out_valid 1 cycle after accept, result=19; SUB same operands → 7; SHL → 13<<6=832.
- MUL 13×6 → out_valid exactly 17 cycles after accept, result=78, remainder=0; in_ready=0 throughout; ALU sel=0000 in every RUN cycle.
- MUL 0xFFFF×0xFFFF → result=0x0001 (wrap); DIV 13/6 → result=2, remainder=1.
- DIV 0xFFFF/0x8001 → result=1, remainder=0x7FFE (exercises R'[WIDTH] overflow); DIV 5/0 → result=0xFFFF, remainder=5, flag_dz=1, latency 1.
- op_sel=1111 → result=0, flag_illegal=1. A second in_valid held during MUL RUN is accepted only on the cycle after the DONE cycle.
- rst asserted at RUN cycle 8 of a DIV → no out_valid; outputs 0; in_ready=1 the cycle after rst drops; a following ADD 13+6 returns 19.
